aec_stream_eval: RTL and testbench
==================================

# aec_stream_eval

Parametrised streaming ASCII arithmetic-expression evaluator, next generation of the team's AEC block. It consumes one character per accepted cycle, with multi-digit hex operands and `+ - * ( )`, and evaluates in a single pass with an operator stack and an operand stack. It emits a `DATA_W`-bit result plus an error code when it sees `=`. It sits behind the character-input front end and feeds the result/status register block.

## Interface
- `DATA_W`, default 16: operand, accumulator and result width.
- `DEPTH`, default 16: entries in each of the operator and operand stacks.
- `MAX_LEN`, default 32: maximum characters per expression, excluding `=`.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: `ascii_in` carries a character this cycle.
- `ascii_in` input, 8 bits: ASCII character.
- `in_ready` output, 1 bit: block accepts a character. A transfer occurs when `in_valid && in_ready`.
- `valid` output, 1 bit: one-cycle pulse; `result` and `err` are meaningful in that cycle.
- `result` output, `DATA_W` bits: expression value, modulo 2^DATA_W.
- `err` output, 2 bits: 0 OK, 1 parentheses illegal, 2 capacity (stack depth or `MAX_LEN`), 3 syntax.

## Operation
Tokens:
- `0`–`9` and `a`–`f` are hex digits. Consecutive digits accumulate as `opnd = opnd*16 + d`, truncated to `DATA_W`.
- The first non-digit after a digit run pushes `opnd` to the operand stack.
- Operators are `+ - * ( ) =`. Any other character is syntax error 3.

Precedence: `*` is above `+` and `-`. All operators are left-associative. `(` is never reduced by a binary operator.

Reduce step, once per cycle: pop operator `op`, pop `b`, pop `a`, push `a op b`.
- Arithmetic is wrap-around in `DATA_W` bits: unsigned add/sub, low `DATA_W` bits of the product.
- If fewer than 2 operands are present, error 3.

States:
- **S_IN**: `in_ready` = 1. Action per character:
  - Digit or `(`: consumed in 1 cycle.
  - `+`, `-`, `*`: if the top operator has precedence ≥ the incoming one, store the character in `pending` and go to S_RED. Otherwise push it.
  - `)`: go to S_RED with pending `)`.
  - `=`: go to S_FIN.
- **S_RED**: `in_ready` = 0. One reduce per cycle until the exit condition holds, then return to S_IN.
  - Pending binary op: exit when the stack is empty, the top is `(`, or the top has lower precedence. Then push `pending`.
  - Pending `)`: exit by popping `(`. An empty stack without `(` is error 1.
- **S_FIN**: `in_ready` = 0. One reduce per cycle until the operator stack is empty.
  - `(` on the stack is error 1.
  - Exactly one operand must remain; otherwise error 3. An empty expression `=` is error 3.
- **S_OUT**: `valid` = 1, `result` = top operand, `err` = 0. Clear both stacks, the accumulator and the length counter. Return to S_IN.
- **S_ERR**: entered on any error with `err` latched; first error wins. `in_ready` = 1.
  - Discard characters until `=`.
  - Then S_OUT with `result` = 0 and the latched `err`.
  - If the error is detected while processing `=` itself, go directly to S_OUT.

Capacity:
- A push onto a full stack is error 2; the push is suppressed.
- A character arriving when the length counter equals `MAX_LEN` is error 2.

## Timing
- Reset values: `valid` 0, `result` 0, `err` 0. State is S_IN, so `in_ready` is 1 on the first cycle after `rst_n` deasserts. Stacks and counters are empty.
- `rst_n` low at any time aborts the expression immediately. No `valid` is produced for it.
- Latency: `=` accepted at cycle T. Reduces occur in T+1 .. T+N, where N is the operators remaining. `valid` is high at T+N+1.
- `in_ready` is low in S_RED, S_FIN and S_OUT.
- The first character of the next expression can be accepted in the cycle after the `valid` pulse.
- `result` and `err` hold their values until the next `valid`.
- Simultaneous events:
  - An operand push and an operator push triggered by the same character both complete in that character's cycle.
  - A full-stack condition detected in that cycle gives error 2 regardless of other checks.

## Structure
- Shared package `aec_pkg`:
  - Token-class enum: DIGIT, OP, LPAR, RPAR, EQ, BAD.
  - Opcode encoding.
  - Precedence function.
  - `err` code constants.
  - ASCII-to-nibble decode function.
- Sub-module `aec_stack #(W, DEPTH)`:
  - Push and pop ports, plus top, second-from-top, full and empty.
  - Instantiated twice: W = `DATA_W` for operands, W = 3 for operators.

## Test plan
- Precedence (`DATA_W` = 16): `3+4*5=` → `valid` with `result` 0x0017, `err` 0, exactly 3 cycles after `=` is accepted. Nested parentheses: `(1+2)*(3+4)=` → 0x0015.
- Multi-digit wrap: `ff*ff=` → 0xFE01. `1-2=` → 0xFFFF. `ffff+2=` → 0x0001.
- Parentheses errors: `(1+2=` → `err` 1, `result` 0. `1+2)=` → `err` 1. Characters after the error are swallowed until `=`.
- Capacity: 17 consecutive `(` with `DEPTH` = 16 → `err` 2. 33 characters with `MAX_LEN` = 32 → `err` 2.
- Syntax: `=` → `err` 3. `1+*2=` → `err` 3. `1#2=` → `err` 3.
- Handshake and reset:
  - Back-to-back `2*3=`, `7-1=` with `in_valid` held high → two `valid` pulses, both 0x0006, with no character lost.
  - `rst_n` pulsed mid-expression → no `valid`, then `5=` → 0x0005.

Source files
------------

// File: rtl/aec_pkg.sv
// Shared types, opcodes, error codes and character decode helpers for the
// streaming expression evaluator.
package aec_pkg;

  typedef enum logic [2:0] {
    TK_DIGIT,
    TK_OP,
    TK_LPAR,
    TK_RPAR,
    TK_EQ,
    TK_BAD
  } tok_e;

  typedef enum logic [2:0] {
    S_IN,
    S_RED,
    S_FIN,
    S_OUT,
    S_ERR
  } state_e;

  localparam logic [2:0] OPC_ADD  = 3'd0;
  localparam logic [2:0] OPC_SUB  = 3'd1;
  localparam logic [2:0] OPC_MUL  = 3'd2;
  localparam logic [2:0] OPC_LPAR = 3'd3;
  localparam logic [2:0] OPC_RPAR = 3'd4;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_PAR = 2'd1;
  localparam logic [1:0] ERR_CAP = 2'd2;
  localparam logic [1:0] ERR_SYN = 2'd3;

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= "0") && (c <= "9")) || ((c >= "a") && (c <= "f"));
  endfunction

  function automatic tok_e classify(input logic [7:0] c);
    tok_e t;
    if (is_hex(c)) begin
      t = TK_DIGIT;
    end else begin
      case (c)
        "+", "-", "*": t = TK_OP;
        "(":           t = TK_LPAR;
        ")":           t = TK_RPAR;
        "=":           t = TK_EQ;
        default:       t = TK_BAD;
      endcase
    end
    return t;
  endfunction

  function automatic logic [3:0] hex_nibble(input logic [7:0] c);
    // 'a' (0x61) minus 0x57 gives 10
    return (c <= "9") ? 4'(c - 8'h30) : 4'(c - 8'h57);
  endfunction

  function automatic logic [2:0] op_code(input logic [7:0] c);
    logic [2:0] o;
    case (c)
      "*":     o = OPC_MUL;
      "-":     o = OPC_SUB;
      "(":     o = OPC_LPAR;
      ")":     o = OPC_RPAR;
      default: o = OPC_ADD;
    endcase
    return o;
  endfunction

  function automatic logic [1:0] prec(input logic [2:0] op);
    logic [1:0] p;
    case (op)
      OPC_MUL:          p = 2'd2;
      OPC_ADD, OPC_SUB: p = 2'd1;
      default:          p = 2'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/aec_stream_eval_stack.sv
// LIFO with combined pop (0..2 entries) and push in one cycle, exposing the
// top two entries, occupancy and full/empty flags.
module aec_stack #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic [1:0]    pop_i,
  output logic [W-1:0]  top_o,
  output logic [W-1:0]  second_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] base;
  logic          push_ok;

  // Pops are applied first so a reduce can overwrite the freed slot in place.
  always_comb begin
    base    = (CW'(pop_i) > count_q) ? '0 : count_q - CW'(pop_i);
    push_ok = push_i && (base < CW'(DEPTH));
    count_d = clear_i ? '0 : base + CW'(push_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) begin
      mem_q[IW'(base)] <= push_data_i;
    end
  end

  assign top_o    = (count_q != '0) ? mem_q[IW'(count_q - CW'(1))] : '0;
  assign second_o = (count_q > CW'(1)) ? mem_q[IW'(count_q - CW'(2))] : '0;
  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;

endmodule

// File: rtl/aec_stream_eval.sv
// Single-pass ASCII hex expression evaluator (+ - * parentheses) using an
// operator stack and an operand stack; reports result and error on '='.
module aec_stream_eval
  import aec_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        ascii_in,
  output logic              in_ready,
  output logic              valid,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic              dig_q, dig_d;
  logic [LW-1:0]     len_q, len_d;
  logic [2:0]        pend_q, pend_d;
  logic [1:0]        err_lat_q, err_lat_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [1:0]        err_q, err_d;

  logic              opd_push;
  logic [1:0]        opd_pop;
  logic [DATA_W-1:0] opd_data;
  logic [DATA_W-1:0] opd_top;
  logic [DATA_W-1:0] opd_second;
  logic              opd_full;
  logic              opd_empty_unused;
  logic [CW-1:0]     opd_cnt;

  logic              opr_push;
  logic [1:0]        opr_pop;
  logic [2:0]        opr_data;
  logic [2:0]        opr_top;
  logic [2:0]        opr_second_unused;
  logic              opr_full;
  logic              opr_empty;
  logic [CW-1:0]     opr_cnt;

  logic              stk_clear;
  logic              accept;
  tok_e              tok;
  logic [3:0]        nib;
  logic [2:0]        inop;
  logic [DATA_W-1:0] alu_res;
  logic              do_reduce;
  logic              cap;
  logic              syn;
  logic              raise;
  logic              raise_out;
  logic [1:0]        raise_code;

  aec_stack #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_opd_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (stk_clear),
    .push_i      (opd_push),
    .push_data_i (opd_data),
    .pop_i       (opd_pop),
    .top_o       (opd_top),
    .second_o    (opd_second),
    .full_o      (opd_full),
    .empty_o     (opd_empty_unused),
    .count_o     (opd_cnt)
  );

  aec_stack #(
    .W     (3),
    .DEPTH (DEPTH)
  ) u_opr_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (stk_clear),
    .push_i      (opr_push),
    .push_data_i (opr_data),
    .pop_i       (opr_pop),
    .top_o       (opr_top),
    .second_o    (opr_second_unused),
    .full_o      (opr_full),
    .empty_o     (opr_empty),
    .count_o     (opr_cnt)
  );

  assign in_ready = (state_q == S_IN) || (state_q == S_ERR);
  assign accept   = in_valid && in_ready;
  assign tok      = classify(ascii_in);
  assign nib      = hex_nibble(ascii_in);
  assign inop     = op_code(ascii_in);

  always_comb begin
    case (opr_top)
      OPC_SUB: alu_res = opd_second - opd_top;
      OPC_MUL: alu_res = opd_second * opd_top;
      default: alu_res = opd_second + opd_top;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    opnd_d     = opnd_q;
    dig_d      = dig_q;
    len_d      = len_q;
    pend_d     = pend_q;
    err_lat_d  = err_lat_q;
    valid_d    = 1'b0;
    result_d   = result_q;
    err_d      = err_q;
    opd_push   = 1'b0;
    opd_pop    = 2'd0;
    opd_data   = opnd_q;
    opr_push   = 1'b0;
    opr_pop    = 2'd0;
    opr_data   = inop;
    stk_clear  = 1'b0;
    do_reduce  = 1'b0;
    cap        = 1'b0;
    syn        = 1'b0;
    raise      = 1'b0;
    raise_out  = 1'b0;
    raise_code = ERR_OK;

    case (state_q)
      S_IN: begin
        if (accept) begin
          if (tok == TK_DIGIT) begin
            cap    = (len_q == LW'(MAX_LEN));
            len_d  = len_q + LW'(1);
            opnd_d = (opnd_q << 4) | DATA_W'(nib);
            dig_d  = 1'b1;
          end else begin
            // The pending operand and any operator push land in the same cycle.
            if (dig_q) begin
              opd_push = 1'b1;
              cap      = opd_full;
              dig_d    = 1'b0;
              opnd_d   = '0;
            end
            if (tok != TK_EQ) begin
              cap   = cap | (len_q == LW'(MAX_LEN));
              len_d = len_q + LW'(1);
            end
            case (tok)
              TK_LPAR: begin
                opr_push = 1'b1;
                cap      = cap | opr_full;
              end
              TK_OP: begin
                if (!opr_empty && (opr_top != OPC_LPAR) &&
                    (prec(opr_top) >= prec(inop))) begin
                  pend_d  = inop;
                  state_d = S_RED;
                end else begin
                  opr_push = 1'b1;
                  cap      = cap | opr_full;
                end
              end
              TK_RPAR: begin
                pend_d  = OPC_RPAR;
                state_d = S_RED;
              end
              TK_EQ: begin
                raise_out = 1'b1;
                if (!opr_empty) begin
                  state_d = S_FIN;
                end else if ((opd_cnt + CW'(dig_q)) == CW'(1)) begin
                  valid_d  = 1'b1;
                  result_d = dig_q ? opnd_q : opd_top;
                  err_d    = ERR_OK;
                  state_d  = S_OUT;
                end else begin
                  syn = 1'b1;
                end
              end
              default: syn = 1'b1;
            endcase
          end
          if (cap) begin
            raise      = 1'b1;
            raise_code = ERR_CAP;
          end else if (syn) begin
            raise      = 1'b1;
            raise_code = ERR_SYN;
          end
        end
      end

      S_RED: begin
        if (pend_q == OPC_RPAR) begin
          if (opr_empty) begin
            raise      = 1'b1;
            raise_code = ERR_PAR;
          end else if (opr_top == OPC_LPAR) begin
            opr_pop = 2'd1;
            state_d = S_IN;
          end else if (opd_cnt < CW'(2)) begin
            raise      = 1'b1;
            raise_code = ERR_SYN;
          end else begin
            do_reduce = 1'b1;
          end
        end else if (opr_empty || (opr_top == OPC_LPAR) ||
                     (prec(opr_top) < prec(pend_q))) begin
          opr_push = 1'b1;
          opr_data = pend_q;
          if (opr_full) begin
            raise      = 1'b1;
            raise_code = ERR_CAP;
          end else begin
            state_d = S_IN;
          end
        end else if (opd_cnt < CW'(2)) begin
          raise      = 1'b1;
          raise_code = ERR_SYN;
        end else begin
          do_reduce = 1'b1;
        end
      end

      S_FIN: begin
        raise_out = 1'b1;
        if (opr_top == OPC_LPAR) begin
          raise      = 1'b1;
          raise_code = ERR_PAR;
        end else if (opd_cnt < CW'(2)) begin
          raise      = 1'b1;
          raise_code = ERR_SYN;
        end else begin
          do_reduce = 1'b1;
          // The last reduce goes straight to the output so valid lands at T+N+1.
          if (opr_cnt == CW'(1)) begin
            if (opd_cnt == CW'(2)) begin
              valid_d  = 1'b1;
              result_d = alu_res;
              err_d    = ERR_OK;
              state_d  = S_OUT;
            end else begin
              raise      = 1'b1;
              raise_code = ERR_SYN;
            end
          end
        end
      end

      S_OUT: begin
        stk_clear = 1'b1;
        opnd_d    = '0;
        dig_d     = 1'b0;
        len_d     = '0;
        err_lat_d = ERR_OK;
        state_d   = S_IN;
      end

      S_ERR: begin
        if (accept && (tok == TK_EQ)) begin
          valid_d  = 1'b1;
          result_d = '0;
          err_d    = err_lat_q;
          state_d  = S_OUT;
        end
      end

      default: state_d = S_IN;
    endcase

    if (do_reduce) begin
      opd_pop  = 2'd2;
      opd_push = 1'b1;
      opd_data = alu_res;
      opr_pop  = 2'd1;
    end

    if (raise) begin
      if (raise_out) begin
        valid_d  = 1'b1;
        result_d = '0;
        err_d    = raise_code;
        state_d  = S_OUT;
      end else begin
        err_lat_d = raise_code;
        state_d   = S_ERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IN;
      opnd_q    <= '0;
      dig_q     <= 1'b0;
      len_q     <= '0;
      pend_q    <= OPC_ADD;
      err_lat_q <= ERR_OK;
      valid_q   <= 1'b0;
      result_q  <= '0;
      err_q     <= ERR_OK;
    end else begin
      state_q   <= state_d;
      opnd_q    <= opnd_d;
      dig_q     <= dig_d;
      len_q     <= len_d;
      pend_q    <= pend_d;
      err_lat_q <= err_lat_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      err_q     <= err_d;
    end
  end

  assign valid  = valid_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_aec_stream_eval.sv
// Directed bench for aec_stream_eval with hand-computed expected results.
module tb_aec_stream_eval;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  ascii_in = 8'h00;
  logic        in_ready;
  logic        valid;
  logic [15:0] result;
  logic [1:0]  err;

  aec_stream_eval #(
    .DATA_W  (16),
    .DEPTH   (16),
    .MAX_LEN (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .ascii_in (ascii_in),
    .in_ready (in_ready),
    .valid    (valid),
    .result   (result),
    .err      (err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned vcount = 0;
  logic [15:0] res_hist [64];
  logic [1:0]  err_hist [64];
  int unsigned cyc_hist [64];

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      res_hist[vcount % 64] = result;
      err_hist[vcount % 64] = err;
      cyc_hist[vcount % 64] = cyc;
      vcount = vcount + 1;
    end
  end

  int unsigned n_total = 0;
  int unsigned n_pass = 0;
  int unsigned last_xfer = 0;
  int unsigned v0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_char(input logic [7:0] c);
    int unsigned w = 0;
    ascii_in = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) check("send_timeout", 32'(in_ready), 32'd1);
    last_xfer = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    in_valid = 1'b0;
  endtask

  task automatic send_rep(input logic [7:0] c, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send_char(c);
  endtask

  task automatic wait_valids(input int unsigned start, input int unsigned n);
    int unsigned w = 0;
    while ((vcount - start) < n && w < 300) begin
      @(posedge clk);
      w++;
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] er, input logic [1:0] ee,
                            input int unsigned start);
    wait_valids(start, 1);
    check({tag, "_valid"}, vcount - start, 32'd1);
    check({tag, "_res"}, 32'(res_hist[start % 64]), 32'(er));
    check({tag, "_err"}, 32'(err_hist[start % 64]), 32'(ee));
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_once"}, vcount - start, 32'd1);
    check({tag, "_hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    v0 = vcount;
    send_str("3+4*5=");
    check("prec_fin_ready_low", 32'(in_ready), 32'd0);
    expect_out("prec", 16'h0017, 2'd0, v0);
    check("prec_latency", cyc_hist[v0 % 64] - last_xfer, 32'd3);

    v0 = vcount; send_str("(1+2)*(3+4)=");  expect_out("paren", 16'h0015, 2'd0, v0);
    v0 = vcount; send_str("ff*ff=");        expect_out("mulwrap", 16'hFE01, 2'd0, v0);
    v0 = vcount; send_str("1-2=");          expect_out("subwrap", 16'hFFFF, 2'd0, v0);
    v0 = vcount; send_str("ffff+2=");       expect_out("addwrap", 16'h0001, 2'd0, v0);

    v0 = vcount; send_str("(1+2=");         expect_out("open_par", 16'h0000, 2'd1, v0);
    v0 = vcount; send_str("1+2)ab*(=");     expect_out("close_par", 16'h0000, 2'd1, v0);

    v0 = vcount; send_rep("(", 16); send_str("=");
    expect_out("depth16", 16'h0000, 2'd1, v0);
    v0 = vcount; send_rep("(", 17); send_str("=");
    expect_out("depth17", 16'h0000, 2'd2, v0);

    v0 = vcount; send_rep("1", 32); send_str("=");
    expect_out("len32", 16'h1111, 2'd0, v0);
    v0 = vcount; send_rep("1", 33); send_str("=");
    expect_out("len33", 16'h0000, 2'd2, v0);

    v0 = vcount; send_str("=");             expect_out("empty", 16'h0000, 2'd3, v0);
    v0 = vcount; send_str("1+*2=");         expect_out("dblop", 16'h0000, 2'd3, v0);
    v0 = vcount; send_str("1#2=");          expect_out("badch", 16'h0000, 2'd3, v0);

    v0 = vcount;
    send_str("2*3=7-1=");
    wait_valids(v0, 2);
    check("b2b_count", vcount - v0, 32'd2);
    check("b2b_res0", 32'(res_hist[v0 % 64]), 32'h6);
    check("b2b_err0", 32'(err_hist[v0 % 64]), 32'd0);
    check("b2b_res1", 32'(res_hist[(v0 + 1) % 64]), 32'h6);
    check("b2b_err1", 32'(err_hist[(v0 + 1) % 64]), 32'd0);

    v0 = vcount;
    send_str("1+2*3");
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_valid_low", 32'(valid), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_valid", vcount - v0, 32'd0);
    v0 = vcount; send_str("5=");            expect_out("after_rst", 16'h0005, 2'd0, v0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
